// File: rtl/mul_int_seq_pkg.sv
// Shared definitions for the sequential integer multiplier and the float units
// that consume its mantissa product.
package mul_int_seq_pkg;

  // Control FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Mantissa width ({hidden bit, fraction}) used by the single-precision float units
  localparam int MANT_W = 24;

endpackage

// File: rtl/mul_int_seq_if.sv
// Start/done handshake and operand/product bus of the sequential multiplier.
interface mul_int_seq_if #(
  parameter int WIDTH = 32
) ();

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  // Requester side: issues operands, observes status and product
  modport master (
    output start, a, b,
    input  busy, done, p
  );

  // Multiplier side
  modport slave (
    input  start, a, b,
    output busy, done, p
  );

endinterface

// File: rtl/mul_int_seq_dp.sv
// Shift-add datapath: multiplicand register, (2*WIDTH+1)-bit product/multiplier
// shift register and the WIDTH+1-bit accumulate adder. Sequencing comes from the top.
module mul_int_seq_dp #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_prod_nxt
);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH:0]   r_prod;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_acc;
  logic [2*WIDTH:0]   w_shift;

  // One radix-2 iteration: conditional add into the upper half, then shift right
  always_comb begin
    w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    if (r_prod[0]) begin
      w_acc = {w_sum, r_prod[WIDTH-1:0]};
    end else begin
      w_acc = r_prod;
    end
    w_shift    = w_acc >> 1'b1;
    // Low 2*WIDTH bits after this iteration; on the last step this is the product
    o_prod_nxt = w_shift[2*WIDTH-1:0];
  end

  // Operand capture on load, one iteration per step, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_prod  <= '0;
    end else if (i_load) begin
      r_mcand <= i_a;
      r_prod  <= {{(WIDTH+1){1'b0}}, i_b};
    end else if (i_step) begin
      r_prod  <= w_shift;
    end else begin
      r_prod  <= r_prod;
    end
  end

endmodule

// File: rtl/mul_int_seq.sv
// Sequential radix-2 unsigned multiplier: control FSM, iteration counter and
// registered handshake outputs. One product every WIDTH+1 cycles.
module mul_int_seq
  import mul_int_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_int_seq_if.slave  bus
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_load;
  logic                 w_step;
  logic                 w_last;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_p;
  logic [2*WIDTH-1:0]   w_prod_nxt;

  mul_int_seq_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_a        (bus.a),
    .i_b        (bus.b),
    .o_prod_nxt (w_prod_nxt)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: DONE accepts a new start just like IDLE, giving back-to-back operation
  always_comb begin
    w_last      = (r_cnt == CNT_LAST);
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath controls: start is only honoured while not running
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      ST_IDLE: w_load = bus.start;
      ST_RUN:  w_step = 1'b1;
      ST_DONE: w_load = bus.start;
      default: begin
        w_load = 1'b0;
        w_step = 1'b0;
      end
    endcase
  end

  // Iteration counter and registered outputs, aligned with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_p    <= '0;
    end else begin
      r_busy <= (w_state_nxt == ST_RUN);
      r_done <= (w_state_nxt == ST_DONE);
      if (w_load) begin
        r_cnt <= '0;
      end else if (w_step && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= r_cnt;
      end
      // Product is taken straight from the final iteration so it appears with done
      if (w_step && w_last) begin
        r_p <= w_prod_nxt;
      end else begin
        r_p <= r_p;
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.p    = r_p;

endmodule
